// File: rtl/multicycle_adder.sv
// Area-reduced adder/subtractor: adds CHUNK bits per clock through a rippled
// full_adder chain, carrying between chunks in a single register.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("multicycle_adder: CHUNK must divide WIDTH with 1 <= CHUNK <= WIDTH");
   end

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic [CHUNK:0]   c_s;
   logic [CHUNK-1:0] sum_s;
   logic [WIDTH-1:0] acc_d, a_d, b_d;

   assign c_s[0] = carry_q;

   for (genvar i = 0; i < CHUNK; i++) begin : g_chain
      full_adder u_fa (
         .a_i(a_q[i]),
         .b_i(b_q[i]),
         .c_i(c_s[i]),
         .s_o(sum_s[i]),
         .c_o(c_s[i+1])
      );
   end

   // Operands shift down one chunk per cycle; sums enter the result from the top.
   if (CHUNK == WIDTH) begin : g_single
      assign acc_d = sum_s;
      assign a_d   = {WIDTH{1'b0}};
      assign b_d   = {WIDTH{1'b0}};
   end else begin : g_multi
      assign acc_d = {sum_s, acc_q[WIDTH-1:CHUNK]};
      assign a_d   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_d   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         carry_q  <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
         s        <= {WIDTH{1'b0}};
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  cnt_q   <= {CW{1'b0}};
                  busy    <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_d;
               b_q     <= b_d;
               acc_q   <= acc_d;
               carry_q <= c_s[CHUNK];
               cnt_q   <= cnt_q + CW'(1);
               // Chain bit CHUNK-1 of the last chunk is the MSB of the word.
               if (cnt_q == LAST) begin
                  s        <= acc_d;
                  cout     <= c_s[CHUNK];
                  overflow <= c_s[CHUNK-1] ^ c_s[CHUNK];
                  zero     <= (acc_d == {WIDTH{1'b0}});
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_adder.sv
// Randomised and directed bench for multicycle_adder with CHUNK = 8, 32 and 1,
// checked against a plain-arithmetic reference model.

module tb_multicycle_adder;
   logic        clk = 1'b0;
   logic        reset, sub, cin;
   logic [31:0] a, b;
   logic [2:0]  start_s, busy_s, done_s, cout_s, ovf_s, zero_s;
   logic [31:0] s_s [3];
   logic [31:0] prev_s [3];
   int          checks = 0, errors = 0;
   int          lat [3] = '{4, 1, 32};

   always #5 clk = ~clk;

   multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start_s[0]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_s[0]), .done(done_s[0]), .s(s_s[0]), .cout(cout_s[0]),
      .overflow(ovf_s[0]), .zero(zero_s[0]));
   multicycle_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clk(clk), .reset(reset), .start(start_s[1]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_s[1]), .done(done_s[1]), .s(s_s[1]), .cout(cout_s[1]),
      .overflow(ovf_s[1]), .zero(zero_s[1]));
   multicycle_adder #(.WIDTH(32), .CHUNK(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start_s[2]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_s[2]), .done(done_s[2]), .s(s_s[2]), .cout(cout_s[2]),
      .overflow(ovf_s[2]), .zero(zero_s[2]));

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: two's-complement arithmetic on a 33-bit sum.
   task automatic ref_model(input logic [31:0] ta, tb, input logic tc, ts,
                            output logic [31:0] es, output logic ec, eo, ez);
      logic [31:0] bb;
      logic [32:0] full;
      bb   = ts ? ~tb : tb;
      full = {1'b0, ta} + {1'b0, bb} + 33'(ts ? 1'b1 : tc);
      es   = full[31:0];
      ec   = full[32];
      eo   = (ta[31] == bb[31]) && (es[31] != ta[31]);
      ez   = (es == 32'd0);
   endtask

   task automatic run_op(input logic [2:0] mask, input logic [31:0] ta, tb,
                         input logic tc, ts);
      logic [31:0] es;
      logic        ec, eo, ez;
      logic [2:0]  pending, just_done;
      ref_model(ta, tb, tc, ts, es, ec, eo, ez);
      for (int i = 0; i < 3; i++) prev_s[i] = s_s[i];
      a = ta; b = tb; cin = tc; sub = ts; start_s = mask;
      tick();
      start_s = 3'b000;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      for (int i = 0; i < 3; i++)
         if (mask[i]) check_eq($sformatf("busy_after_start[%0d]", i), 64'(busy_s[i]), 64'd1);
      pending   = mask;
      just_done = 3'b000;
      for (int cyc = 1; cyc <= 40 && (pending != 3'b000 || just_done != 3'b000); cyc++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (just_done[i]) begin
               check_eq($sformatf("done_pulse_width[%0d]", i), 64'(done_s[i]), 64'd0);
               just_done[i] = 1'b0;
            end else if (pending[i]) begin
               if (done_s[i]) begin
                  check_eq($sformatf("latency[%0d]", i), 64'(cyc), 64'(lat[i]));
                  check_eq($sformatf("s[%0d]", i), 64'(s_s[i]), 64'(es));
                  check_eq($sformatf("cout[%0d]", i), 64'(cout_s[i]), 64'(ec));
                  check_eq($sformatf("overflow[%0d]", i), 64'(ovf_s[i]), 64'(eo));
                  check_eq($sformatf("zero[%0d]", i), 64'(zero_s[i]), 64'(ez));
                  check_eq($sformatf("busy_at_done[%0d]", i), 64'(busy_s[i]), 64'd0);
                  pending[i]   = 1'b0;
                  just_done[i] = 1'b1;
               end else begin
                  check_eq($sformatf("s_held[%0d]", i), 64'(s_s[i]), 64'(prev_s[i]));
               end
            end
         end
      end
      check_eq("completion_timeout", 64'(pending), 64'd0);
   endtask

   initial begin
      logic [31:0] es;
      logic        ec, eo, ez;
      reset = 1'b1; start_s = 3'b000; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("rst_busy[%0d]", i), 64'(busy_s[i]), 64'd0);
         check_eq($sformatf("rst_done[%0d]", i), 64'(done_s[i]), 64'd0);
         check_eq($sformatf("rst_s[%0d]", i), 64'(s_s[i]), 64'd0);
         check_eq($sformatf("rst_flags[%0d]", i),
                  64'({cout_s[i], ovf_s[i], zero_s[i]}), 64'd0);
      end

      // Directed corner cases on the CHUNK=8 instance.
      run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(3'b001, 32'd5, 32'd7, 1'b0, 1'b1);
      run_op(3'b001, 32'd7, 32'd5, 1'b1, 1'b1);
      run_op(3'b001, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      run_op(3'b001, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
      check_eq("directed_sum", 64'(s_s[0]), 64'h2345_678A);

      // Starts during RUN are ignored; start in the done cycle is accepted.
      a = 32'd1; b = 32'd1; cin = 1'b0; sub = 1'b0; start_s = 3'b001;
      tick();
      a = 32'd9; b = 32'd9;
      tick(); tick(); tick();
      start_s = 3'b000;
      tick();
      check_eq("ignored_start_done", 64'(done_s[0]), 64'd1);
      check_eq("ignored_start_s", 64'(s_s[0]), 64'd2);
      a = 32'd3; b = 32'd4; start_s = 3'b001;
      tick();
      start_s = 3'b000;
      check_eq("b2b_busy", 64'(busy_s[0]), 64'd1);
      check_eq("b2b_done_drop", 64'(done_s[0]), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("b2b_s_hold", 64'({done_s[0], s_s[0]}), 64'd2);
      end
      tick();
      check_eq("b2b_result", 64'({done_s[0], s_s[0]}), {31'd0, 1'b1, 32'd7});

      // Reset in the second RUN cycle aborts the operation.
      a = 32'd10; b = 32'd20; start_s = 3'b001;
      tick();
      start_s = 3'b000;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("abort_outputs",
               64'({busy_s[0], done_s[0], cout_s[0], ovf_s[0], zero_s[0], s_s[0]}), 64'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("abort_no_done", 64'(done_s[0]), 64'd0);
      end
      run_op(3'b001, 32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0);
      ref_model(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0, es, ec, eo, ez);
      check_eq("post_abort_s", 64'(s_s[0]), 64'(es));

      // Random vectors across all three chunk sizes.
      for (int v = 0; v < 1000; v++)
         run_op(3'b111, $urandom, $urandom, 1'($urandom), 1'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
